// File: rtl/ex_stage_pipe.sv
// ex_stage_pipe: registered execute stage with MEM/WB operand forwarding, B-operand select, ALU and NZCV flags.
// Latency: 1 cycle from accept to out_valid; result, store data and destination held until out_ready.
// Backpressure: in_ready = !out_valid || out_ready; flush empties the stage and blocks accept that cycle.
// Optional: define EX_STAGE_STALL_CNT_EN to build the saturating stall counter behind stall_cnt.
module ex_stage_pipe #(
  parameter int WIDTH    = 64,
  parameter int NREG     = 32,
  parameter int ZERO_REG = 31,
  localparam int RIDX    = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RIDX-1:0]  in_rn_idx,
  input  logic [RIDX-1:0]  in_rm_idx,
  input  logic [WIDTH-1:0] in_rn_val,
  input  logic [WIDTH-1:0] in_rm_val,
  input  logic [WIDTH-1:0] in_imm,
  input  logic             in_use_imm,
  input  logic [2:0]       in_aluop,
  input  logic             in_flagwrite,
  input  logic [RIDX-1:0]  in_rd_idx,
  input  logic             in_regwrite,
  input  logic             mem_fwd_en,
  input  logic [RIDX-1:0]  mem_fwd_idx,
  input  logic [WIDTH-1:0] mem_fwd_data,
  input  logic             wb_fwd_en,
  input  logic [RIDX-1:0]  wb_fwd_idx,
  input  logic [WIDTH-1:0] wb_fwd_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [WIDTH-1:0] out_store_data,
  output logic [RIDX-1:0]  out_rd_idx,
  output logic             out_regwrite,
  output logic             out_zero,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic [31:0]      stall_cnt
);

  localparam logic [RIDX-1:0] ZR      = RIDX'(ZERO_REG);
  localparam logic [2:0]      OP_PASS = 3'b000;
  localparam logic [2:0]      OP_ADD  = 3'b010;
  localparam logic [2:0]      OP_SUB  = 3'b011;
  localparam logic [2:0]      OP_AND  = 3'b100;
  localparam logic [2:0]      OP_OR   = 3'b101;
  localparam logic [2:0]      OP_XOR  = 3'b110;

  logic             accept;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] fwd_rm;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] b_add;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;

  // Zero register wins, then the younger MEM result, then WB, then the register file.
  function automatic logic [WIDTH-1:0] fwd_sel(
    input logic [RIDX-1:0]  idx,
    input logic [WIDTH-1:0] rf_val,
    input logic             m_en,
    input logic [RIDX-1:0]  m_idx,
    input logic [WIDTH-1:0] m_dat,
    input logic             w_en,
    input logic [RIDX-1:0]  w_idx,
    input logic [WIDTH-1:0] w_dat
  );
    if (idx == ZR)                     return '0;
    else if (m_en && (m_idx == idx))   return m_dat;
    else if (w_en && (w_idx == idx))   return w_dat;
    else                               return rf_val;
  endfunction

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  assign op_a   = fwd_sel(in_rn_idx, in_rn_val, mem_fwd_en, mem_fwd_idx, mem_fwd_data,
                          wb_fwd_en, wb_fwd_idx, wb_fwd_data);
  assign fwd_rm = fwd_sel(in_rm_idx, in_rm_val, mem_fwd_en, mem_fwd_idx, mem_fwd_data,
                          wb_fwd_en, wb_fwd_idx, wb_fwd_data);
  assign op_b   = in_use_imm ? in_imm : fwd_rm;

  // ALU: a single adder serves add and sub (A + ~B + 1); carry/overflow only for those two ops.
  always_comb begin
    b_add   = op_b;
    cin     = 1'b0;
    if (in_aluop == OP_SUB) begin
      b_add = ~op_b;
      cin   = 1'b1;
    end
    sum     = {1'b0, op_a} + {1'b0, b_add} + {{WIDTH{1'b0}}, cin};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (in_aluop)
      OP_PASS: alu_res = op_b;
      OP_ADD, OP_SUB: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (op_a[WIDTH-1] == b_add[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      default: alu_res = '0;
    endcase
  end

  // Output register and flag register: flush kills, accept loads, drain empties.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid      <= 1'b0;
      out_result     <= '0;
      out_store_data <= '0;
      out_rd_idx     <= '0;
      out_regwrite   <= 1'b0;
      out_zero       <= 1'b0;
      flag_n         <= 1'b0;
      flag_z         <= 1'b0;
      flag_c         <= 1'b0;
      flag_v         <= 1'b0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid      <= 1'b1;
        out_result     <= alu_res;
        out_store_data <= fwd_rm;
        out_rd_idx     <= in_rd_idx;
        out_regwrite   <= in_regwrite;
        out_zero       <= (alu_res == '0);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept && in_flagwrite) begin
        flag_n <= alu_res[WIDTH-1];
        flag_z <= (alu_res == '0);
        flag_c <= alu_c;
        flag_v <= alu_v;
      end
    end
  end

`ifdef EX_STAGE_STALL_CNT_EN
  // Count cycles where a result sits blocked by downstream; saturates, cleared by flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (flush) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`else
  assign stall_cnt = '0;
`endif

endmodule
